stop_sequencer: RTL and testbench
=================================

// Module: stop_sequencer
// PURPOSE
//  Upstream job controller for the counter stage. It queues stop-value jobs from a valid/ready source
//  and programs the counter's stop input. It holds the counter in reset between jobs, releases it per job
//  and watches done. Each finished job is returned downstream as a tagged result holding the cycle count.
// PARAMETERS
//  STOP_WIDTH  3  width of stop values; must equal the counter's STOP_WIDTH
//  DEPTH       4  job FIFO entries (power of 2, >=2)
//  TAG_WIDTH   4  job tag width
//  CYC_WIDTH   8  result cycle-count width; must be >= STOP_WIDTH+1
//  TIMEOUT     6  RUN-cycle limit; used only with STOP_SEQ_TIMEOUT_EN
// PORTS
//  clk          in   1          clock
//  reset_l      in   1          reset, asynchronous, active-low
//  in_valid     in   1          job offered
//  in_ready     out  1          job accepted when in_valid&&in_ready
//  in_stop      in   STOP_WIDTH stop value of the job
//  in_tag       in   TAG_WIDTH  job tag
//  cnt_reset_l  out  1          drives the counter's reset_l; registered, glitch-free
//  cnt_stop     out  STOP_WIDTH drives the counter's stop
//  cnt_done     in   1          counter's done
//  out_valid    out  1          result available
//  out_ready    in   1          result consumed when out_valid&&out_ready
//  out_tag      out  TAG_WIDTH  tag of finished job
//  out_cycles   out  CYC_WIDTH  RUN cycles until done was seen
//  out_err      out  1          job aborted by timeout
//  busy         out  1          state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset values: in_ready=0 while reset_l is low, then 1. All other outputs are 0.
//    cnt_reset_l=0, so the counter is held in reset. FIFO is empty and state=IDLE.
//  - FIFO: in_ready = !full, with no pass-through when full.
//    Push and pop in the same cycle are legal when not full; count is unchanged.
//  - FSM IDLE->CLEAR->RUN->REPORT->IDLE:
//    - IDLE: cnt_reset_l=0. If the FIFO is non-empty, pop the head and latch stop and tag.
//      On the next edge cnt_stop=stop and the state goes to CLEAR. If empty, stay in IDLE.
//    - CLEAR: one cycle. cnt_reset_l is still 0 and cnt_stop is stable.
//      Next edge: cnt_reset_l<=1, cyc<=0, go to RUN.
//    - RUN: the counter reads 0 in the first RUN cycle. Each cycle, sample cnt_done.
//      - If cnt_done=1: out_cycles<=cyc, out_err<=0, go to REPORT.
//      - Else: cyc<=cyc+1, saturating at all-ones.
//      - Result: out_cycles equals the job's stop value; stop=0 finishes in the first RUN cycle.
//    - REPORT: out_valid=1. out_tag, out_cycles and out_err stay stable until out_ready.
//      On the handshake edge: out_valid<=0, cnt_reset_l<=0, go to IDLE.
//      No new job is popped while in REPORT.
//  - Latency: a push accepted into an empty FIFO in IDLE appears at the head 1 edge later.
//    The counter is released 3 edges after acceptance. out_valid rises stop+1 edges after release.
//  - cnt_stop changes only in IDLE, while the counter is held in reset.
//  - cnt_done is ignored outside RUN, including any assertion while held in reset.
//  - reset_l asserted mid-job: everything returns to reset values immediately and the FIFO is flushed.
//    The in-flight job is lost and no result is produced for it.
//  - Back-to-back jobs: a new job is popped in the first IDLE cycle after REPORT.
// CONFIGURATION
//  STOP_SEQ_TIMEOUT_EN defined:
//   - In RUN, if cyc==TIMEOUT and cnt_done=0, go to REPORT with out_err=1, out_cycles=TIMEOUT.
//   - If cnt_done=1 in the same cycle, done wins and out_err=0.
//  STOP_SEQ_TIMEOUT_EN undefined:
//   - No timeout logic. out_err is tied to 0 and TIMEOUT is ignored.
//   - Completion is guaranteed within 2^STOP_WIDTH RUN cycles by counter wrap.
// TESTING
//  1. Reset: hold reset_l=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, cnt_reset_l=0, busy=0.
//     After release, push 2 jobs and assert reset_l=0 mid-RUN.
//     -> cnt_reset_l=0 at once, FIFO empty, no out_valid after re-release.
//  2. Single job stop=5 tag=3 with out_ready=1:
//     -> cnt_reset_l rises 3 edges after accept, out_valid 6 edges later.
//     -> out_tag=3, out_cycles=5, out_err=0, busy=0 afterwards.
//  3. Job stop=0 tag=1 -> out_cycles=0, out_valid 1 edge after cnt_reset_l rises.
//  4. With out_ready=0, push 6 jobs with tags 0..5 and stops 1..6:
//     -> DEPTH=4 accepted, plus 1 popped into the active job; in_ready=0 on the 6th.
//     -> After out_ready=1: results appear in tag order 0..5 with out_cycles 1..6.
//  5. Hold out_ready=0 for 10 cycles in REPORT:
//     -> out_valid stays 1, payload unchanged, cnt_reset_l stays 1, FIFO head not popped.
//  6. STOP_WIDTH=3, TIMEOUT=6, stop=7:
//     -> With STOP_SEQ_TIMEOUT_EN: out_err=1, out_cycles=6.
//     -> Without: out_err=0, out_cycles=7.

Source files
------------

// File: rtl/stop_seq_if.sv
// stop_seq_if: bundles the job input, counter control and result output
// of the stop sequencer.
//
//   master modport: the sequencer's view. It drives in_ready, cnt_reset_l,
//                   cnt_stop, out_valid, out_tag, out_cycles, out_err and busy.
//   slave modport : the environment's view (job source, counter, result sink).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. A producer keeps valid and its payload stable until that
// edge. ready may not depend combinationally on valid.
interface stop_seq_if #(
    parameter int STOP_WIDTH = 3,
    parameter int TAG_WIDTH  = 4,
    parameter int CYC_WIDTH  = 8
);
    // job input
    logic                  in_valid;
    logic                  in_ready;
    logic [STOP_WIDTH-1:0] in_stop;
    logic [TAG_WIDTH-1:0]  in_tag;
    // counter control
    logic                  cnt_reset_l;
    logic [STOP_WIDTH-1:0] cnt_stop;
    logic                  cnt_done;
    // result output
    logic                  out_valid;
    logic                  out_ready;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic [CYC_WIDTH-1:0]  out_cycles;
    logic                  out_err;
    // status
    logic                  busy;

    modport master (
        input  in_valid, in_stop, in_tag, cnt_done, out_ready,
        output in_ready, cnt_reset_l, cnt_stop, out_valid, out_tag,
               out_cycles, out_err, busy
    );

    modport slave (
        output in_valid, in_stop, in_tag, cnt_done, out_ready,
        input  in_ready, cnt_reset_l, cnt_stop, out_valid, out_tag,
               out_cycles, out_err, busy
    );
endinterface

// File: rtl/stop_sequencer.sv
// stop_sequencer: job controller for the stop counter.
//
// Accepts (stop, tag) jobs into a small FIFO, programs the counter's stop
// value while the counter is held in reset, releases the counter for one
// job at a time, and returns a tagged result carrying the number of RUN
// cycles until the counter reported done.
//
// Ports:
//   clk        clock
//   reset_l    asynchronous, active-low reset
//   bus        stop_seq_if.master: job input (in_*), counter control
//              (cnt_reset_l, cnt_stop, cnt_done), result output (out_*), busy
//   dbg_state  current FSM state (0 IDLE, 1 CLEAR, 2 RUN, 3 REPORT)
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready is registered and equals !full. out_valid and the
// result payload are held stable until out_ready is seen.
//
// Optional feature: define STOP_SEQ_TIMEOUT_EN to abort a job that has not
// finished after TIMEOUT RUN cycles (reported with out_err=1). Without it
// out_err is tied to 0 and TIMEOUT is only range-checked.
module stop_sequencer #(
    parameter int STOP_WIDTH = 3,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int CYC_WIDTH  = 8,
    parameter int TIMEOUT    = 6
) (
    input  logic        clk,
    input  logic        reset_l,
    stop_seq_if.master  bus,
    output logic [1:0]  dbg_state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    // Elaboration-time parameter sanity checks.
    if (CYC_WIDTH < STOP_WIDTH + 1) begin : g_bad_cyc_width
        $error("stop_sequencer: CYC_WIDTH must be >= STOP_WIDTH+1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("stop_sequencer: DEPTH must be a power of 2 and >= 2");
    end
    if ((TIMEOUT < 0) || (TIMEOUT >= (1 << CYC_WIDTH))) begin : g_bad_timeout
        $error("stop_sequencer: TIMEOUT must fit in CYC_WIDTH bits");
    end

    // ------------------------------------------------------------------
    // Job FIFO
    // ------------------------------------------------------------------
    logic [STOP_WIDTH-1:0] stop_mem [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  in_ready_q;
    logic                  head_seen_q;
    logic                  push;
    logic                  pop;

    assign push = bus.in_valid && in_ready_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; only pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stop_mem[wr_ptr_q] <= bus.in_stop;
            tag_mem[wr_ptr_q]  <= bus.in_tag;
        end
    end

    // head_seen_q is count_q!=0 delayed by one edge: a job pushed into an
    // empty FIFO becomes visible to the FSM one edge after acceptance.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            head_seen_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            in_ready_q  <= (count_d != CNT_W'(DEPTH));
            head_seen_q <= (count_q != '0);
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t                state_q,       state_d;
    logic                  cnt_reset_l_q, cnt_reset_l_d;
    logic [STOP_WIDTH-1:0] cnt_stop_q,    cnt_stop_d;
    logic [TAG_WIDTH-1:0]  job_tag_q,     job_tag_d;
    logic [CYC_WIDTH-1:0]  cyc_q,         cyc_d;
    logic                  out_valid_q,   out_valid_d;
    logic [TAG_WIDTH-1:0]  out_tag_q,     out_tag_d;
    logic [CYC_WIDTH-1:0]  out_cycles_q,  out_cycles_d;
`ifdef STOP_SEQ_TIMEOUT_EN
    localparam logic [CYC_WIDTH-1:0] TIMEOUT_CYC = CYC_WIDTH'(TIMEOUT);
    logic                  out_err_q,     out_err_d;
`endif

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= S_IDLE;
            cnt_reset_l_q <= 1'b0;
            cnt_stop_q    <= '0;
            job_tag_q     <= '0;
            cyc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_tag_q     <= '0;
            out_cycles_q  <= '0;
`ifdef STOP_SEQ_TIMEOUT_EN
            out_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_reset_l_q <= cnt_reset_l_d;
            cnt_stop_q    <= cnt_stop_d;
            job_tag_q     <= job_tag_d;
            cyc_q         <= cyc_d;
            out_valid_q   <= out_valid_d;
            out_tag_q     <= out_tag_d;
            out_cycles_q  <= out_cycles_d;
`ifdef STOP_SEQ_TIMEOUT_EN
            out_err_q     <= out_err_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        cnt_reset_l_d = cnt_reset_l_q;
        cnt_stop_d    = cnt_stop_q;
        job_tag_d     = job_tag_q;
        cyc_d         = cyc_q;
        out_valid_d   = out_valid_q;
        out_tag_d     = out_tag_q;
        out_cycles_d  = out_cycles_q;
`ifdef STOP_SEQ_TIMEOUT_EN
        out_err_d     = out_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Counter stays in reset; cnt_stop may only change here.
                cnt_reset_l_d = 1'b0;
                if (head_seen_q && (count_q != '0)) begin
                    pop        = 1'b1;
                    cnt_stop_d = stop_mem[rd_ptr_q];
                    job_tag_d  = tag_mem[rd_ptr_q];
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // One settling cycle with cnt_stop stable, then release.
                cnt_reset_l_d = 1'b1;
                cyc_d         = '0;
                state_d       = S_RUN;
            end
            S_RUN: begin
                // cnt_done has priority over the timeout in the same cycle.
                if (bus.cnt_done) begin
                    out_valid_d  = 1'b1;
                    out_tag_d    = job_tag_q;
                    out_cycles_d = cyc_q;
`ifdef STOP_SEQ_TIMEOUT_EN
                    out_err_d    = 1'b0;
`endif
                    state_d      = S_REPORT;
                end
`ifdef STOP_SEQ_TIMEOUT_EN
                else if (cyc_q == TIMEOUT_CYC) begin
                    out_valid_d  = 1'b1;
                    out_tag_d    = job_tag_q;
                    out_cycles_d = TIMEOUT_CYC;
                    out_err_d    = 1'b1;
                    state_d      = S_REPORT;
                end
`endif
                else if (cyc_q != '1) begin
                    cyc_d = cyc_q + CYC_WIDTH'(1);
                end
            end
            S_REPORT: begin
                // Counter keeps running here; its done is ignored.
                if (bus.out_ready) begin
                    out_valid_d   = 1'b0;
                    cnt_reset_l_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready_q;
    assign bus.cnt_reset_l = cnt_reset_l_q;
    assign bus.cnt_stop    = cnt_stop_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_cycles  = out_cycles_q;
`ifdef STOP_SEQ_TIMEOUT_EN
    assign bus.out_err     = out_err_q;
`else
    assign bus.out_err     = 1'b0;
`endif
    assign bus.busy        = (state_q != S_IDLE) || (count_q != '0);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_stop_sequencer.sv
// tb_stop_sequencer: self-checking bench for stop_sequencer.
// Models the counter (counts from 0 while released, done when count==stop)
// and predicts each job's result from the job alone.
module tb_stop_sequencer;
    localparam int SW      = 3;
    localparam int DEPTH   = 4;
    localparam int TW      = 4;
    localparam int CW      = 8;
    localparam int TIMEOUT = 6;
    localparam int RW      = TW + CW + 1;

    logic          clk;
    logic          reset_l;
    logic [1:0]    dbg_state;
    logic          done_noise;
    logic [SW-1:0] ctr;
    int            vectors;
    int            miscompares;
    int unsigned   cyc_n;
    int            stop_chg_bad;
    logic [SW-1:0] prev_stop;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    stop_seq_if #(.STOP_WIDTH(SW), .TAG_WIDTH(TW), .CYC_WIDTH(CW)) bus ();

    stop_sequencer #(
        .STOP_WIDTH(SW), .DEPTH(DEPTH), .TAG_WIDTH(TW),
        .CYC_WIDTH(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / counter model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk or negedge bus.cnt_reset_l) begin
        if (!bus.cnt_reset_l) ctr <= '0;
        else                  ctr <= ctr + SW'(1);
    end
    // While held in reset the counter's done line carries random noise.
    assign bus.cnt_done = bus.cnt_reset_l ? (ctr == bus.cnt_stop) : done_noise;

    // Result monitor and cnt_stop stability watch.
    always @(negedge clk) begin
        if (reset_l && bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_tag, bus.out_cycles, bus.out_err});
        if (bus.cnt_reset_l && (bus.cnt_stop !== prev_stop)) stop_chg_bad <= stop_chg_bad + 1;
        prev_stop <= bus.cnt_stop;
    end

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] model_result(input logic [SW-1:0] s, input logic [TW-1:0] t);
        logic [CW-1:0] c;
        logic          e;
        c = CW'(s);
        e = 1'b0;
`ifdef STOP_SEQ_TIMEOUT_EN
        if (int'(s) > TIMEOUT) begin
            c = CW'(TIMEOUT);
            e = 1'b1;
        end
`endif
        return {t, c, e};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_job(input logic [SW-1:0] s, input logic [TW-1:0] t,
                            input int max_wait, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_stop  = s;
        bus.in_tag   = t;
        for (int i = 0; i < max_wait; i++) begin
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        if (ok) exp_q.push_back(model_result(s, t));
    endtask

    task automatic wait_rel(input int max_wait, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (bus.cnt_reset_l) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(input int max_wait, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (bus.out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input int max_wait, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if ((got_q.size() >= exp_q.size()) && !bus.busy && !bus.out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        int saw;
        reset_l = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b exp 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b exp 0", bus.out_valid); end
        vectors++; if (bus.cnt_reset_l !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_reset_l: got %0b exp 0", bus.cnt_reset_l); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b exp 0", bus.busy); end
        vectors++; if ({bus.out_tag, bus.out_cycles, bus.out_err, bus.cnt_stop} !== '0) begin
            miscompares++; $display("FAIL reset_payload: got %0h exp 0", {bus.out_tag, bus.out_cycles, bus.out_err, bus.cnt_stop}); end
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state_idle: got %0d exp 0", dbg_state); end
        bus.in_valid = 1'b0;
        reset_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %0b exp 1", bus.in_ready); end
        // Two jobs, then reset while the first is in RUN.
        bus.out_ready = 1'b1;
        push_job(3'd6, 4'd2, 4, ok);
        push_job(3'd5, 4'd4, 4, ok);
        wait_rel(10, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL midrun_release: got no release exp release"); end
        repeat (2) @(posedge clk);
        #3 reset_l = 1'b0;
        #1;
        vectors++; if (bus.cnt_reset_l !== 1'b0) begin miscompares++; $display("FAIL midrun_cnt_reset_l: got %0b exp 0", bus.cnt_reset_l); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrun_flush_busy: got %0b exp 0", bus.busy); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrun_in_ready: got %0b exp 0", bus.in_ready); end
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        exp_q.delete();
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw++;
        end
        vectors++; if (saw != 0) begin miscompares++; $display("FAIL midrun_no_result: got %0d valid cycles exp 0", saw); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrun_fifo_empty: got busy=%0b exp 0", bus.busy); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL midrun_no_handshake: got %0d exp 0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic run_single(input string name, input logic [SW-1:0] s, input logic [TW-1:0] t);
        bit ok;
        int unsigned t_acc, t_rel, t_v;
        logic [RW-1:0] e;
        e = model_result(s, t);
        bus.out_ready = 1'b1;
        push_job(s, t, 4, ok);
        t_acc = cyc_n;
        vectors++; if (!ok) begin miscompares++; $display("FAIL %s_accept: got refused exp accepted", name); end
        wait_rel(10, ok);
        t_rel = cyc_n;
        vectors++; if (!ok || (t_rel - t_acc) != 3) begin
            miscompares++; $display("FAIL %s_release_latency: got %0d exp 3", name, t_rel - t_acc); end
        wait_valid(20, ok);
        t_v = cyc_n;
        vectors++; if (!ok || (t_v - t_rel) != int'(s) + 1) begin
            miscompares++; $display("FAIL %s_valid_latency: got %0d exp %0d", name, t_v - t_rel, int'(s) + 1); end
        vectors++; if ({bus.out_tag, bus.out_cycles, bus.out_err} !== e) begin
            miscompares++; $display("FAIL %s_result: got %0h exp %0h", name, {bus.out_tag, bus.out_cycles, bus.out_err}, e); end
        @(posedge clk); #1;
        vectors++; if ({bus.busy, bus.out_valid, bus.cnt_reset_l} !== 3'b000) begin
            miscompares++; $display("FAIL %s_after: got busy/valid/rel=%03b exp 000", name, {bus.busy, bus.out_valid, bus.cnt_reset_l}); end
        vectors++; if (got_q.size() != 1 || got_q[0] !== e) begin
            miscompares++; $display("FAIL %s_handshake: got %0d results exp 1 of %0h", name, got_q.size(), e); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single();
        run_single("single", 3'd5, 4'd3);
    endtask

    task automatic test_stop_zero();
        run_single("stop0", 3'd0, 4'd1);
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc;
        bus.out_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            push_job(SW'(j + 1), TW'(j), 2, ok);
            if (ok) acc++;
        end
        vectors++; if (acc != DEPTH + 1) begin miscompares++; $display("FAIL bp_accepted: got %0d exp %0d", acc, DEPTH + 1); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_full: got %0b exp 0", bus.in_ready); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %0b exp 1", bus.busy); end
        bus.out_ready = 1'b1;
        push_job(3'd6, 4'd5, 60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_sixth_accept: got refused exp accepted"); end
        wait_drain(200, ok);
        vectors++; if (!ok || got_q.size() != 6 || exp_q.size() != 6) begin
            miscompares++; $display("FAIL bp_count: got %0d exp 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL bp_result%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_hold();
        bit ok;
        logic [RW-1:0] e;
        e = model_result(3'd2, 4'd7);
        bus.out_ready = 1'b0;
        push_job(3'd2, 4'd7, 4, ok);
        push_job(3'd3, 4'd8, 4, ok);
        wait_valid(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL hold_valid: got no valid exp valid"); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if ({bus.out_valid, bus.out_tag, bus.out_cycles, bus.out_err} !== {1'b1, e}) begin
                miscompares++; $display("FAIL hold_payload%0d: got %0h exp %0h", i,
                    {bus.out_valid, bus.out_tag, bus.out_cycles, bus.out_err}, {1'b1, e}); end
            vectors++; if ({bus.cnt_reset_l, bus.cnt_stop} !== {1'b1, 3'd2}) begin
                miscompares++; $display("FAIL hold_counter%0d: got %0h exp %0h", i, {bus.cnt_reset_l, bus.cnt_stop}, {1'b1, 3'd2}); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_drain(60, ok);
        vectors++; if (!ok || got_q.size() != 2) begin miscompares++; $display("FAIL hold_count: got %0d exp 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL hold_result%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        bus.out_ready = 1'b1;
        push_job(3'd7, 4'd9, 4, ok);
        push_job(3'd6, 4'd10, 4, ok);
        wait_drain(80, ok);
        vectors++; if (!ok || got_q.size() != 2) begin miscompares++; $display("FAIL timeout_count: got %0d exp 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL timeout_result%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        bit rnd_done;
        int refused;
        rnd_done = 1'b0;
        refused = 0;
        stop_chg_bad = 0;
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    push_job(SW'($urandom_range(0, 7)), TW'(j), 100, ok);
                    if (!ok) refused++;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    done_noise    = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        done_noise = 1'b0;
        vectors++; if (refused != 0) begin miscompares++; $display("FAIL rnd_push_timeout: got %0d refused exp 0", refused); end
        wait_drain(1000, ok);
        vectors++; if (!ok || got_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL rnd_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rnd_result%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (stop_chg_bad != 0) begin
            miscompares++; $display("FAIL rnd_cnt_stop_stable: got %0d changes while released exp 0", stop_chg_bad); end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc_n         = 0;
        stop_chg_bad  = 0;
        done_noise    = 1'b0;
        reset_l       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_stop   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_stop_zero();
        test_backpressure();
        test_hold();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion exp completion before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
